// File: rtl/tag_lookup_array_if.sv
// Lookup/response, fill and flush-control bundle for tag_lookup_array.
// The array side uses the slave modport; the requesting pipeline uses master.
interface tag_lookup_array_if #(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned TAG_WIDTH  = 20,
    parameter int unsigned META_WIDTH = 1
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    logic                             lookup_valid_i;
    logic                             lookup_ready_o;
    logic [IDX_W-1:0]                 lookup_index_i;
    logic [TAG_WIDTH-1:0]             lookup_tag_i;
    logic                             resp_valid_o;
    logic                             resp_hit_o;
    logic [NUM_WAYS-1:0]              resp_hit_way_o;
    logic [NUM_WAYS*TAG_WIDTH-1:0]    resp_tag_o;
    logic [NUM_WAYS*META_WIDTH-1:0]   resp_meta_o;
    logic [NUM_WAYS-1:0]              we_way_mask_i;
    logic [IDX_W-1:0]                 w_index_i;
    logic [TAG_WIDTH-1:0]             wdata_tag_i;
    logic [META_WIDTH-1:0]            wdata_meta_i;
    logic                             flush_i;
    logic                             flush_busy_o;
    logic                             parity_err_o;

    modport master (
        output lookup_valid_i, lookup_index_i, lookup_tag_i,
        output we_way_mask_i, w_index_i, wdata_tag_i, wdata_meta_i, flush_i,
        input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_hit_way_o,
        input  resp_tag_o, resp_meta_o, flush_busy_o, parity_err_o
    );

    modport slave (
        input  lookup_valid_i, lookup_index_i, lookup_tag_i,
        input  we_way_mask_i, w_index_i, wdata_tag_i, wdata_meta_i, flush_i,
        output lookup_ready_o, resp_valid_o, resp_hit_o, resp_hit_way_o,
        output resp_tag_o, resp_meta_o, flush_busy_o, parity_err_o
    );
endinterface

// File: rtl/tag_lookup_array.sv
// Set-associative tag/metadata store: registered hit-compare lookup, masked fill
// and an invalidate-all sweep. Optional per-entry parity: TAG_ARRAY_PARITY_EN.
module tag_lookup_array #(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned TAG_WIDTH  = 20,
    parameter int unsigned META_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tag_lookup_array_if.slave     bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    typedef enum logic {ST_FLUSH, ST_IDLE} state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [IDX_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     w_cnt_nxt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 w_sweep;
    logic                 w_fill_en;
    logic                 w_accept;

    logic [TAG_WIDTH-1:0]  r_tag  [NUM_WAYS][NUM_SETS];
    logic [META_WIDTH-1:0] r_meta [NUM_WAYS][NUM_SETS];

    logic [NUM_WAYS-1:0]            w_fwd;
    logic [NUM_WAYS-1:0]            w_perr;
    logic [NUM_WAYS-1:0]            w_hit_way;
    logic [NUM_WAYS*TAG_WIDTH-1:0]  w_rd_tag;
    logic [NUM_WAYS*META_WIDTH-1:0] w_rd_meta;

    logic                           r_resp_valid;
    logic                           r_resp_hit;
    logic [NUM_WAYS-1:0]            r_resp_hit_way;
    logic [NUM_WAYS*TAG_WIDTH-1:0]  r_resp_tag;
    logic [NUM_WAYS*META_WIDTH-1:0] r_resp_meta;

    // Sequencer state and the registered ready/busy flags that mirror it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt == ST_FLUSH);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep     = 1'b0;
        w_fill_en   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_FLUSH: begin
                w_sweep   = 1'b1;
                w_cnt_nxt = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(NUM_SETS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                w_fill_en = |bus.we_way_mask_i;
                w_accept  = bus.lookup_valid_i;
                if (bus.flush_i) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_FLUSH;
        endcase
    end

`ifdef TAG_ARRAY_PARITY_EN
    logic r_par [NUM_WAYS][NUM_SETS];
    logic r_perr;
`endif

    // Storage: the sweep clears metadata (tags kept), fills write masked ways
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w_sweep) begin
                    r_meta[w][r_cnt] <= '0;
`ifdef TAG_ARRAY_PARITY_EN
                    r_par[w][r_cnt]  <= ^r_tag[w][r_cnt];
`endif
                end else if (w_fill_en && bus.we_way_mask_i[w]) begin
                    r_tag[w][bus.w_index_i]  <= bus.wdata_tag_i;
                    r_meta[w][bus.w_index_i] <= bus.wdata_meta_i;
`ifdef TAG_ARRAY_PARITY_EN
                    r_par[w][bus.w_index_i]  <= ^{bus.wdata_tag_i, bus.wdata_meta_i};
`endif
                end
            end
        end
    end

    // Per-way read with write-first forwarding from a same-cycle fill
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        assign w_fwd[g] = w_fill_en && bus.we_way_mask_i[g]
                          && (bus.w_index_i == bus.lookup_index_i);
        assign w_rd_tag[g*TAG_WIDTH +: TAG_WIDTH] = w_fwd[g] ? bus.wdata_tag_i
                                                    : r_tag[g][bus.lookup_index_i];
        assign w_rd_meta[g*META_WIDTH +: META_WIDTH] = w_fwd[g] ? bus.wdata_meta_i
                                                       : r_meta[g][bus.lookup_index_i];
`ifdef TAG_ARRAY_PARITY_EN
        assign w_perr[g] = !w_fwd[g] && (^{r_tag[g][bus.lookup_index_i],
                                           r_meta[g][bus.lookup_index_i],
                                           r_par[g][bus.lookup_index_i]});
`else
        assign w_perr[g] = 1'b0;
`endif
        assign w_hit_way[g] = w_rd_meta[g*META_WIDTH]
                              && (w_rd_tag[g*TAG_WIDTH +: TAG_WIDTH] == bus.lookup_tag_i)
                              && !w_perr[g];
    end

    // Response registers hold their contents between strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_hit_way <= '0;
            r_resp_tag     <= '0;
            r_resp_meta    <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_resp_hit     <= |w_hit_way;
                r_resp_hit_way <= w_hit_way;
                r_resp_tag     <= w_rd_tag;
                r_resp_meta    <= w_rd_meta;
            end
        end
    end

`ifdef TAG_ARRAY_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_accept && (|w_perr);
        end
    end
    assign bus.parity_err_o = r_perr;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.lookup_ready_o = r_ready;
    assign bus.flush_busy_o   = r_busy;
    assign bus.resp_valid_o   = r_resp_valid;
    assign bus.resp_hit_o     = r_resp_hit;
    assign bus.resp_hit_way_o = r_resp_hit_way;
    assign bus.resp_tag_o     = r_resp_tag;
    assign bus.resp_meta_o    = r_resp_meta;
endmodule

// File: tb/tb_tag_lookup_array.sv
// Randomized self-checking bench for tag_lookup_array against a set/way array model.
// Build with or without TAG_ARRAY_PARITY_EN; the model follows the same macro.
module tb_tag_lookup_array;
    localparam int unsigned NW = 4;
    localparam int unsigned NS = 256;
    localparam int unsigned TW = 20;
`ifdef TAG_ARRAY_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tag_lookup_array_if bus ();
    tag_lookup_array dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: stored tag, valid bit, "tag known" and "parity corrupted" per entry
    logic [TW-1:0] m_tag   [NW][NS];
    logic          m_meta  [NW][NS];
    bit            m_known [NW][NS];
    bit            m_bad   [NW][NS];

    logic [NW-1:0]    e_way;
    logic [NW*TW-1:0] e_tag, e_kmask;
    logic [NW-1:0]    e_meta;
    logic             e_perr;
    logic [NW-1:0]    l_way;
    logic [NW*TW-1:0] l_tag, l_kmask;
    logic [NW-1:0]    l_meta;
    logic [TW-1:0]    pool [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sweep();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                m_meta[w][s] = 1'b0;
                m_bad[w][s]  = 1'b0;
            end
    endtask

    task automatic clear_last();
        l_way = '0; l_tag = '0; l_kmask = '1; l_meta = '0;
    endtask

    // Expected response from model contents with same-cycle fill taking priority
    task automatic predict(input int idx, input logic [TW-1:0] t, input logic [NW-1:0] mask,
                           input int widx, input logic [TW-1:0] wt, input logic wm);
        e_perr = 1'b0;
        for (int w = 0; w < NW; w++) begin
            logic [TW-1:0] st;
            logic          sm;
            bit            bad, kn;
            st = m_tag[w][idx]; sm = m_meta[w][idx]; bad = m_bad[w][idx]; kn = m_known[w][idx];
            if (mask[w] && widx == idx) begin
                st = wt; sm = wm; bad = 1'b0; kn = 1'b1;
            end
            e_tag[w*TW +: TW]   = st;
            e_kmask[w*TW +: TW] = kn ? {TW{1'b1}} : '0;
            e_meta[w]           = sm;
            e_way[w]            = sm && (st == t) && !(PAR && bad);
            if (PAR && bad) e_perr = 1'b1;
        end
    endtask

    // One clock: drive a lookup/fill/flush, check the response to it after the edge
    task automatic do_cycle(input bit v, input int idx, input logic [TW-1:0] t,
                            input logic [NW-1:0] mask, input int widx,
                            input logic [TW-1:0] wt, input logic wm, input bit fl, input bit rdy);
        bit acc;
        check("ready", bus.lookup_ready_o, rdy);
        bus.lookup_valid_i = v;
        bus.lookup_index_i = 8'(idx);
        bus.lookup_tag_i   = t;
        bus.we_way_mask_i  = mask;
        bus.w_index_i      = 8'(widx);
        bus.wdata_tag_i    = wt;
        bus.wdata_meta_i   = wm;
        bus.flush_i        = fl;
        acc = v && rdy;
        if (acc) predict(idx, t, mask, widx, wt, wm);
        tick();
        bus.lookup_valid_i = 1'b0;
        bus.we_way_mask_i  = '0;
        bus.flush_i        = 1'b0;
        check("resp_valid", bus.resp_valid_o, acc);
        if (acc) begin
            check("hit_way", bus.resp_hit_way_o, e_way);
            check("hit", bus.resp_hit_o, |e_way);
            check("resp_tag", bus.resp_tag_o & e_kmask, e_tag & e_kmask);
            check("resp_meta", bus.resp_meta_o, e_meta);
            check("parity_err", bus.parity_err_o, e_perr);
            l_way = e_way; l_tag = e_tag; l_kmask = e_kmask; l_meta = e_meta;
        end else begin
            check("hold_way", bus.resp_hit_way_o, l_way);
            check("hold_tag", bus.resp_tag_o & l_kmask, l_tag & l_kmask);
            check("hold_meta", bus.resp_meta_o, l_meta);
            check("parity_idle", bus.parity_err_o, 1'b0);
        end
        if (rdy)
            for (int w = 0; w < NW; w++)
                if (mask[w]) begin
                    m_tag[w][widx] = wt; m_meta[w][widx] = wm;
                    m_known[w][widx] = 1'b1; m_bad[w][widx] = 1'b0;
                end
    endtask

    // Count busy samples from now; pokes a rejected lookup, a dropped fill and a held flush
    task automatic wait_sweep();
        int  n;
        bit  early;
        n = 0; early = 1'b0;
        while (bus.flush_busy_o === 1'b1 && n < 400) begin
            n++;
            if (bus.lookup_ready_o !== 1'b0) early = 1'b1;
            if (n == 3)       do_cycle(1, 5, 20'hABCDE, 4'b0100, 5, 20'hABCDE, 1'b1, 0, 0);
            else if (n == 10) do_cycle(0, 0, '0, '0, 0, '0, 1'b0, 1, 0);
            else              tick();
        end
        check("busy_cycles", 128'(n), 128'(NS));
        check("ready_while_busy", early, 1'b0);
        check("ready_after_sweep", bus.lookup_ready_o, 1'b1);
        model_sweep();
    endtask

    initial begin
        bus.lookup_valid_i = 1'b0; bus.lookup_index_i = '0; bus.lookup_tag_i = '0;
        bus.we_way_mask_i  = '0;   bus.w_index_i = '0;      bus.wdata_tag_i = '0;
        bus.wdata_meta_i   = '0;   bus.flush_i = 1'b0;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                m_tag[w][s] = '0; m_meta[w][s] = 1'b0; m_known[w][s] = 1'b0; m_bad[w][s] = 1'b0;
            end
        for (int i = 0; i < 8; i++) pool[i] = TW'($urandom);
        clear_last();

        // Reset values, then the power-on sweep
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", bus.lookup_ready_o, 1'b0);
        check("rst_busy", bus.flush_busy_o, 1'b1);
        check("rst_valid", bus.resp_valid_o, 1'b0);
        check("rst_hit", bus.resp_hit_o, 1'b0);
        check("rst_way", bus.resp_hit_way_o, '0);
        check("rst_tag", bus.resp_tag_o, '0);
        check("rst_meta", bus.resp_meta_o, '0);
        check("rst_perr", bus.parity_err_o, 1'b0);
        rst = 1'b0;
        wait_sweep();

        do_cycle(1, 0, '0, '0, 0, '0, 1'b0, 0, 1);

        // Give sets 0..15 known contents
        for (int s = 0; s < 16; s++)
            do_cycle(0, 0, '0, 4'hF, s, pool[$urandom_range(0, 7)], 1'($urandom), 0, 1);

        // Fill then lookup next cycle; same-cycle fill with forwarding
        do_cycle(0, 0, '0, 4'b0100, 5, 20'hABCDE, 1'b1, 0, 1);
        do_cycle(1, 5, 20'hABCDE, '0, 0, '0, 1'b0, 0, 1);
        check("dir_way_set5", bus.resp_hit_way_o, 4'b0100);
        do_cycle(1, 9, 20'h12345, 4'b0010, 9, 20'h12345, 1'b1, 0, 1);
        check("dir_way_set9", bus.resp_hit_way_o, 4'b0010);

        // Random lookups and fills over a small index/tag space to force hits and forwarding
        for (int i = 0; i < 400; i++) begin
            int            idx, widx;
            logic [TW-1:0] t;
            logic [NW-1:0] mask;
            idx  = $urandom_range(0, 15);
            widx = ($urandom_range(0, 2) == 0) ? idx : $urandom_range(0, 15);
            t    = pool[$urandom_range(0, 7)];
            mask = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            do_cycle($urandom_range(0, 3) != 0, idx, t, mask, widx,
                     pool[$urandom_range(0, 7)], 1'($urandom), 0, 1);
        end

        // Corrupt a stored tag bit behind the parity bit
        do_cycle(0, 0, '0, 4'b0001, 7, 20'h00001, 1'b1, 0, 1);
        dut.r_tag[0][7] = 20'h00000;
        m_tag[0][7] = 20'h00000;
        m_bad[0][7] = 1'b1;
        do_cycle(1, 7, 20'h00001, '0, 0, '0, 1'b0, 0, 1);
        do_cycle(1, 7, 20'h00000, '0, 0, '0, 1'b0, 0, 1);
        check("perr_dir", bus.parity_err_o, PAR);

        // Flush with a same-cycle lookup on pre-flush contents
        do_cycle(1, 9, 20'h12345, 4'b1000, 3, pool[0], 1'b1, 1, 1);
        wait_sweep();
        do_cycle(1, 5, 20'hABCDE, '0, 0, '0, 1'b0, 0, 1);
        check("post_flush_miss", bus.resp_hit_o, 1'b0);
        check("post_flush_meta", bus.resp_meta_o, '0);
        do_cycle(1, 7, 20'h00000, '0, 0, '0, 1'b0, 0, 1);

        // Reset in the middle of a sweep restarts it
        do_cycle(0, 0, '0, '0, 0, '0, 1'b0, 1, 1);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_last();
        check("midrst_valid", bus.resp_valid_o, 1'b0);
        wait_sweep();
        for (int i = 0; i < 20; i++)
            do_cycle(1, $urandom_range(0, 15), pool[$urandom_range(0, 7)],
                     NW'($urandom), $urandom_range(0, 15), pool[$urandom_range(0, 7)], 1'b1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tag_lookup_array.md
# tag_lookup_array

Parametrised set-associative tag/metadata store with a registered hit-compare lookup port, a single-way-mask fill port, and a hardware invalidate-all sequencer. It sits in the cache pipeline between the index/tag split stage and the hit/miss controller. Lookups return one cycle after acceptance, with per-way hit flags. The array is swept invalid automatically after reset and on demand.

## Interface
- NUM_WAYS, 4, associativity
- NUM_SETS, 256, sets per way; power of two, ≥2; IDX_W = $clog2(NUM_SETS)
- TAG_WIDTH, 20, tag bits
- META_WIDTH, 1, metadata bits per entry; bit 0 is Valid, upper bits opaque (e.g. Dirty)
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup accepted when valid&&ready
- lookup_index_i  in  IDX_W  set index
- lookup_tag_i  in  TAG_WIDTH  compare tag
- resp_valid_o  out  1  one-cycle response strobe
- resp_hit_o  out  1  OR of resp_hit_way_o
- resp_hit_way_o  out  NUM_WAYS  per-way hit flags
- resp_tag_o  out  NUM_WAYS×TAG_WIDTH  stored tags of looked-up set
- resp_meta_o  out  NUM_WAYS×META_WIDTH  stored metadata of looked-up set
- we_way_mask_i  in  NUM_WAYS  fill write enable per way
- w_index_i  in  IDX_W  fill set index
- wdata_tag_i  in  TAG_WIDTH  fill tag
- wdata_meta_i  in  META_WIDTH  fill metadata
- flush_i  in  1  start invalidate-all (level sampled in IDLE)
- flush_busy_o  out  1  sweep in progress
- parity_err_o  out  1  parity error strobe, aligned with resp_valid_o

## Operation
- FSM states: FLUSH, IDLE. rst_i high → FLUSH, set counter=0.
- FLUSH: each cycle writes meta=0 (tag unchanged) in all ways of set[counter]; counter increments; at counter==NUM_SETS-1 the set is cleared and the FSM moves to IDLE. flush_busy_o=1, lookup_ready_o=0.
- IDLE: lookup_ready_o=1, flush_busy_o=0. flush_i=1 → FLUSH, counter=0.
- flush_i during FLUSH ignored; sweep does not restart.
- Fill writes (we_way_mask_i≠0) in IDLE: every masked way at w_index_i takes {wdata_tag_i, wdata_meta_i}. Fill writes in FLUSH are dropped.
- Lookup: on accept, the set is read and per-way hit = meta[0] && (tag==lookup_tag_i). Results are registered.
- Write-first forwarding: a fill and an accepted lookup to the same index in the same cycle → written ways return the new tag/meta and are compared against it.
- Multiple hit bits are reported raw; tag uniqueness per set is the fill controller's responsibility.
- flush_i and an accepted lookup in the same IDLE cycle: lookup uses pre-flush contents; ready drops next cycle.
- rst_i mid-sweep: counter returns to 0 and the full sweep restarts.

## Timing
- While rst_i high: lookup_ready_o=0, flush_busy_o=1, resp_valid_o=0, resp_hit_o=0, resp_hit_way_o=0, resp_tag_o=0, resp_meta_o=0, parity_err_o=0.
- After rst_i falls: flush_busy_o high for exactly NUM_SETS cycles; lookup_ready_o rises on cycle NUM_SETS.
- Lookup latency: accept at edge N → resp_* valid in cycle N+1, resp_valid_o high exactly one cycle per accept. resp_* hold their values between strobes.
- Back-to-back lookups sustain one per cycle in IDLE.
- Flush from IDLE: flush_i seen at edge N → ready low from N+1 for NUM_SETS cycles.
- Fill write visible to a lookup in the same cycle via forwarding, otherwise from the next cycle.

## Configuration
- TAG_ARRAY_PARITY_EN defined: each entry stores one even-parity bit over {tag, meta}. Fill writes compute it; the sweep writes parity of {tag, 0}. On lookup, a way with a mismatch is forced to miss, and parity_err_o pulses with resp_valid_o.
- Undefined: no parity storage, no check; parity_err_o tied 0. The port is always present.

## Test plan
- Reset 3 cycles, release → flush_busy_o=1 for 256 cycles, lookup_ready_o=0 until cycle 256, then 1. A lookup of set 0, tag 0 gives resp_hit_o=0.
- Fill way 2 at set 5 with tag 0xABCDE, meta 1. Next cycle, look up set 5, tag 0xABCDE → one cycle later resp_hit_way_o=4'b0100, resp_hit_o=1, resp_tag_o[2]=0xABCDE.
- Same-cycle fill of way 1 at set 9 with tag 0x12345, meta 1, plus a lookup of set 9, tag 0x12345 → response hit, resp_hit_way_o=4'b0010.
- With the array filled, assert flush_i for 1 cycle. A lookup issued while ready=0 is not accepted. After 256 cycles, a lookup of set 5, tag 0xABCDE → miss, resp_meta_o all 0. Fills issued during the sweep are lost.
- Assert rst_i at sweep counter 100 → restart; flush_busy_o is 1 for 256 further cycles after release.
- TAG_ARRAY_PARITY_EN: fill set 7 way 0 with tag 0x00001, then deposit a flipped tag bit → lookup miss, parity_err_o=1 with resp_valid_o. Without the macro, same stimulus → parity_err_o=0.
